// File: rtl/stage2_pkg.sv
// Shared types and constants for the STAGE2 sequencer.
package stage2_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;

  // mblock code that selects the PC path (never reads a RAM operand)
  localparam logic [2:0] MBLOCK_PC = 3'b111;
  // mblock bit that, when set, means the operand does not come from RAM
  localparam int MBLOCK_IMM_BIT = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // True when the instruction needs a RAM operand read before the ALU result is usable.
  function automatic logic needs_ram_read(input logic [2:0] mblock);
    return (mblock != MBLOCK_PC) && (mblock[MBLOCK_IMM_BIT] == 1'b0);
  endfunction

endpackage

// File: rtl/stage2_sequencer_ack_timer.sv
// Ack watchdog: counts cycles spent waiting for a RAM handshake.
// 'expired' is high during the last allowed wait cycle (count == LIMIT-1).
module ack_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clear wins over enable; otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/stage2_sequencer.sv
// Multi-cycle controller for the STAGE2 datapath: accept one instruction, hold the
// STAGE2 selects, optionally read a RAM operand, sample the ALU, optionally write back,
// then hand the result and branch decision downstream.
module stage2_sequencer
  import stage2_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mblock,
  input  logic [3:0]        in_alu_op,
  input  logic [7:0]        in_vr_source,
  input  logic [7:0]        in_vrw_source,
  input  logic              in_wb_en,
  input  logic              in_is_branch,
  output logic [2:0]        s2_mblock,
  output logic [3:0]        s2_alu_op,
  output logic [7:0]        s2_vr_source,
  output logic [7:0]        s2_vrw_source,
  input  logic [ADDR_W-1:0] s2_ram_address,
  input  logic [DATA_W-1:0] s2_vw_value,
  input  logic              s2_alu_is_zero,
  output logic              ram_rd_req,
  input  logic              ram_rd_ack,
  output logic              ram_wr_req,
  input  logic              ram_wr_ack,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_branch,
  output logic              timeout_err
);

  state_t              state_q, state_d;
  logic [2:0]          mblock_q, mblock_d;
  logic [3:0]          alu_op_q, alu_op_d;
  logic [7:0]          vr_q, vr_d;
  logic [7:0]          vrw_q, vrw_d;
  logic                wb_en_q, wb_en_d;
  logic                is_branch_q, is_branch_d;
  logic                from_read_q, from_read_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                branch_q, branch_d;
  logic                timeout_err_q, timeout_err_d;
  logic                in_ready_q, in_ready_d;
  logic                rd_req_q, rd_req_d;
  logic                wr_req_q, wr_req_d;
  logic                out_valid_q, out_valid_d;

  logic                timer_clear;
  logic                timer_en;
  logic                timer_expired;

  ack_timer #(
    .LIMIT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // Next-state, capture and handshake-flag logic; everything holds unless a state acts.
  always_comb begin
    state_d       = state_q;
    mblock_d      = mblock_q;
    alu_op_d      = alu_op_q;
    vr_d          = vr_q;
    vrw_d         = vrw_q;
    wb_en_d       = wb_en_q;
    is_branch_d   = is_branch_q;
    from_read_d   = from_read_q;
    result_d      = result_q;
    wr_addr_d     = wr_addr_q;
    branch_d      = branch_q;
    timeout_err_d = timeout_err_q;
    timer_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mblock_d    = in_mblock;
          alu_op_d    = in_alu_op;
          vr_d        = in_vr_source;
          vrw_d       = in_vrw_source;
          wb_en_d     = in_wb_en;
          is_branch_d = in_is_branch;
          from_read_d = needs_ram_read(in_mblock);
          state_d     = needs_ram_read(in_mblock) ? S_READ : S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        // RAM data is only guaranteed during the ack cycle, so the ALU is sampled here.
        if (ram_rd_ack) begin
          result_d  = s2_vw_value;
          branch_d  = is_branch_q & s2_alu_is_zero;
          wr_addr_d = s2_ram_address;
          state_d   = S_EXEC;
        end else if (timer_expired) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      S_EXEC: begin
        if (!from_read_q) begin
          result_d  = s2_vw_value;
          branch_d  = is_branch_q & s2_alu_is_zero;
          wr_addr_d = s2_ram_address;
        end else begin
          result_d = result_q;
        end
        state_d = wb_en_q ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        if (ram_wr_ack) begin
          state_d = S_DONE;
        end else if (timer_expired) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The wait counter restarts whenever the state changes.
    timer_clear = (state_d != state_q);

    in_ready_d  = (state_d == S_IDLE);
    rd_req_d    = (state_d == S_READ);
    wr_req_d    = (state_d == S_WRITE);
    out_valid_d = (state_d == S_DONE);
  end

  // State, captured instruction, results and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mblock_q      <= 3'd0;
      alu_op_q      <= 4'd0;
      vr_q          <= 8'd0;
      vrw_q         <= 8'd0;
      wb_en_q       <= 1'b0;
      is_branch_q   <= 1'b0;
      from_read_q   <= 1'b0;
      result_q      <= 32'd0;
      wr_addr_q     <= 16'd0;
      branch_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      in_ready_q    <= 1'b1;
      rd_req_q      <= 1'b0;
      wr_req_q      <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mblock_q      <= mblock_d;
      alu_op_q      <= alu_op_d;
      vr_q          <= vr_d;
      vrw_q         <= vrw_d;
      wb_en_q       <= wb_en_d;
      is_branch_q   <= is_branch_d;
      from_read_q   <= from_read_d;
      result_q      <= result_d;
      wr_addr_q     <= wr_addr_d;
      branch_q      <= branch_d;
      timeout_err_q <= timeout_err_d;
      in_ready_q    <= in_ready_d;
      rd_req_q      <= rd_req_d;
      wr_req_q      <= wr_req_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign s2_mblock     = mblock_q;
  assign s2_alu_op     = alu_op_q;
  assign s2_vr_source  = vr_q;
  assign s2_vrw_source = vrw_q;
  assign ram_rd_req    = rd_req_q;
  assign ram_wr_req    = wr_req_q;
  assign ram_wr_addr   = wr_addr_q;
  assign ram_wr_data   = result_q;
  assign out_valid     = out_valid_q;
  assign out_result    = result_q;
  assign out_branch    = branch_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_stage2_sequencer.sv
// Scoreboard bench for stage2_sequencer with a small STAGE2 ALU / RAM stub.
module tb_stage2_sequencer;
  import stage2_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  in_mblock;
  logic [3:0]  in_alu_op;
  logic [7:0]  in_vr_source, in_vrw_source;
  logic        in_wb_en, in_is_branch;
  logic [2:0]  s2_mblock;
  logic [3:0]  s2_alu_op;
  logic [7:0]  s2_vr_source, s2_vrw_source;
  logic [15:0] s2_ram_address;
  logic [31:0] s2_vw_value;
  logic        s2_alu_is_zero;
  logic        ram_rd_req, ram_rd_ack, ram_wr_req, ram_wr_ack;
  logic [15:0] ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_branch, timeout_err;
  logic [31:0] ram_value;
  logic [31:0] stub_a;

  typedef struct {
    logic [31:0] result;
    logic        branch;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stage2_sequencer #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mblock(in_mblock), .in_alu_op(in_alu_op),
    .in_vr_source(in_vr_source), .in_vrw_source(in_vrw_source),
    .in_wb_en(in_wb_en), .in_is_branch(in_is_branch),
    .s2_mblock(s2_mblock), .s2_alu_op(s2_alu_op),
    .s2_vr_source(s2_vr_source), .s2_vrw_source(s2_vrw_source),
    .s2_ram_address(s2_ram_address), .s2_vw_value(s2_vw_value),
    .s2_alu_is_zero(s2_alu_is_zero),
    .ram_rd_req(ram_rd_req), .ram_rd_ack(ram_rd_ack),
    .ram_wr_req(ram_wr_req), .ram_wr_ack(ram_wr_ack),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_branch(out_branch),
    .timeout_err(timeout_err)
  );

  // 0 = ADD, 1 = SUB, anything else = AND
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      default: return a & b;
    endcase
  endfunction

  // STAGE2 stub: operand A is RAM data unless mblock bit 2 selects vrw_source.
  assign stub_a         = s2_mblock[2] ? {24'd0, s2_vrw_source} : ram_value;
  assign s2_vw_value    = alu_model(s2_alu_op, stub_a, {24'd0, s2_vr_source});
  assign s2_alu_is_zero = (s2_vw_value == 32'd0);
  assign s2_ram_address = {s2_vrw_source, s2_vr_source};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    check_eq({tag, ":ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic accept(input logic [2:0] mb, input logic [3:0] op, input logic [7:0] vr,
                        input logic [7:0] vrw, input logic wb, input logic br);
    in_valid = 1'b1; in_mblock = mb; in_alu_op = op;
    in_vr_source = vr; in_vrw_source = vrw; in_wb_en = wb; in_is_branch = br;
    tick();
    in_valid = 1'b0;
    in_mblock = 3'($urandom); in_alu_op = 4'($urandom);
    in_vr_source = 8'($urandom); in_vrw_source = 8'($urandom);
    in_wb_en = 1'($urandom); in_is_branch = 1'($urandom);
  endtask

  // Full instruction: push expectation, serve acks, pop and compare at out_valid.
  task automatic run_instr(input string tag, input logic [2:0] mb, input logic [3:0] op,
                           input logic [7:0] vr, input logic [7:0] vrw, input logic wb,
                           input logic br, input int rd_dly, input int wr_dly,
                           input logic [31:0] rv, input int hold);
    logic        need_rd;
    logic [31:0] a;
    logic [31:0] exp_res;
    exp_t        e;
    int          lat, rd_cyc, wr_cyc, guard, exp_lat;
    need_rd = (mb != 3'b111) && !mb[2];
    a       = need_rd ? rv : {24'd0, vrw};
    exp_res = alu_model(op, a, {24'd0, vr});
    sb_q.push_back('{result: exp_res, branch: br & (exp_res == 32'd0)});
    exp_lat = 2 + (need_rd ? rd_dly + 1 : 0) + (wb ? wr_dly + 1 : 0);

    wait_ready(tag);
    accept(mb, op, vr, vrw, wb, br);
    lat = 1; rd_cyc = 0; wr_cyc = 0; guard = 0;
    while (!out_valid && guard < 200) begin
      if (ram_rd_req) begin
        if (rd_cyc == rd_dly) begin
          ram_rd_ack = 1'b1;
          ram_value  = rv;
        end
        rd_cyc++;
      end
      if (ram_wr_req) begin
        check_eq({tag, ":wr_addr"}, {16'd0, ram_wr_addr}, {16'd0, vrw, vr});
        check_eq({tag, ":wr_data"}, ram_wr_data, exp_res);
        if (wr_cyc == wr_dly) ram_wr_ack = 1'b1;
        wr_cyc++;
      end
      tick();
      ram_rd_ack = 1'b0;
      ram_wr_ack = 1'b0;
      ram_value  = 32'hDEAD_BEEF;
      lat++;
      guard++;
    end
    check_eq({tag, ":out_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, ":latency"}, lat, exp_lat);
    check_eq({tag, ":rd_cycles"}, rd_cyc, need_rd ? rd_dly + 1 : 0);
    check_eq({tag, ":wr_cycles"}, wr_cyc, wb ? wr_dly + 1 : 0);
    e = sb_q.pop_front();
    check_eq({tag, ":result"}, out_result, e.result);
    check_eq({tag, ":branch"}, {31'd0, out_branch}, {31'd0, e.branch});
    check_eq({tag, ":s2_sel"}, {12'd0, s2_mblock, s2_alu_op, s2_vr_source, s2_vrw_source},
             {12'd0, mb, op, vr, vrw});
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq({tag, ":done_hold"}, {out_valid, out_result[30:0]}, {1'b1, e.result[30:0]});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, ":release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int guard, rd_cyc;
    reset = 1'b1; in_valid = 1'b0; in_mblock = 3'd0; in_alu_op = 4'd0;
    in_vr_source = 8'd0; in_vrw_source = 8'd0; in_wb_en = 1'b0; in_is_branch = 1'b0;
    ram_rd_ack = 1'b0; ram_wr_ack = 1'b0; out_ready = 1'b0; ram_value = 32'hDEAD_BEEF;
    tick();
    tick();
    check_eq("reset:flags", {26'd0, in_ready, ram_rd_req, ram_wr_req, out_valid, out_branch,
             timeout_err}, 32'h20);
    check_eq("reset:result", out_result, 32'd0);
    check_eq("reset:s2_sel", {12'd0, s2_mblock, s2_alu_op, s2_vr_source, s2_vrw_source}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Acks with no request outstanding must be ignored.
    ram_rd_ack = 1'b1; ram_wr_ack = 1'b1;
    tick();
    ram_rd_ack = 1'b0; ram_wr_ack = 1'b0;
    tick();
    check_eq("spurious_ack", {29'd0, in_ready, out_valid, ram_rd_req}, 32'h4);

    run_instr("imm_add",   3'b100, 4'd0, 8'd3,    8'd4,    1'b0, 1'b0, 0, 0, 32'd0,          0);
    run_instr("rd_add",    3'b000, 4'd0, 8'd7,    8'd0,    1'b0, 1'b0, 3, 0, 32'd5,          0);
    run_instr("rd_and_wb", 3'b001, 4'd2, 8'h3C,   8'h12,   1'b1, 1'b0, 0, 2, 32'hF0F0_00FF,  2);
    run_instr("br_eq",     3'b100, 4'd1, 8'd9,    8'd9,    1'b0, 1'b1, 0, 0, 32'd0,          0);
    run_instr("br_ne",     3'b101, 4'd1, 8'd3,    8'd9,    1'b0, 1'b1, 0, 0, 32'd0,          1);
    run_instr("pc_wb",     3'b111, 4'd0, 8'hA0,   8'h05,   1'b1, 1'b0, 0, 0, 32'd0,          0);

    // Read never acknowledged: abort after TO cycles, no result.
    wait_ready("timeout");
    accept(3'b000, 4'd0, 8'd1, 8'd2, 1'b0, 1'b0);
    check_eq("timeout:err_before", {31'd0, timeout_err}, 32'd0);
    rd_cyc = 0; guard = 0;
    while (ram_rd_req && guard < 50) begin
      check_eq("timeout:no_valid", {31'd0, out_valid}, 32'd0);
      rd_cyc++;
      tick();
      guard++;
    end
    check_eq("timeout:cycles", rd_cyc, TO);
    check_eq("timeout:err", {31'd0, timeout_err}, 32'd1);
    check_eq("timeout:idle", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("timeout:discard", {31'd0, out_valid}, 32'd0);
    end

    run_instr("after_to", 3'b110, 4'd0, 8'd10, 8'd20, 1'b0, 1'b0, 0, 0, 32'd0, 0);
    check_eq("sticky_err", {31'd0, timeout_err}, 32'd1);

    // Reset in the middle of a write.
    wait_ready("rst_wr");
    accept(3'b100, 4'd0, 8'd1, 8'd1, 1'b1, 1'b0);
    guard = 0;
    while (!ram_wr_req && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("rst_wr:req_before", {31'd0, ram_wr_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_wr:flags", {28'd0, ram_wr_req, in_ready, timeout_err, out_valid}, 32'h4);
    @(negedge clk);
    reset = 1'b0;
    tick();

    run_instr("recover", 3'b000, 4'd1, 8'd2, 8'd0, 1'b1, 1'b0, 1, 1, 32'd100, 0);
    check_eq("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
